mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the multi-cycle core.
- Allows a single outstanding transaction. The winner's request is latched, issued downstream with a valid/ready handshake, and the response is routed back to the owner.
- Priority is fixed with LSU first; a starvation limit guarantees IFU progress.
- A per-transaction timeout converts a missing response into an error response.

Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants allowed while IFU is waiting before IFU is forced to win (range 1..15).
- TIMEOUT, 255: cycles from entering REQ without mem_resp_valid before an error response is returned; 0 disables the timeout (range 0..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU read address
- ifu_resp_valid  out  1  IFU response pulse
- ifu_resp_data  out  32  IFU read data
- ifu_resp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  LSU response pulse (reads and writes)
- lsu_resp_data  out  32  LSU read data
- lsu_resp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  32  latched address
- mem_wen  out  1  latched write enable (always 0 for IFU)
- mem_wdata  out  32  latched write data (0 for IFU)
- mem_wmask  out  4  latched write mask (0 for IFU)
- mem_resp_valid  in  1  downstream response valid; no backpressure
- mem_resp_data  in  32  downstream read data

Behaviour:
- Reset (synchronous, active-high): state=IDLE, owner=IFU, starve_cnt=0, tmo_cnt=0, all latched request fields 0, every output 0. Reset mid-transaction abandons the transaction with no response pulse; a later mem_resp_valid is ignored.
- States: IDLE, REQ, WAIT.
- IDLE, arbitration:
  - If lsu_req_valid and not (ifu_req_valid and starve_cnt==STARVE_LIMIT), grant LSU.
  - Otherwise, if ifu_req_valid, grant IFU.
  - The winner's req_ready is asserted combinationally in this cycle, only in IDLE, and for at most one requester. The loser sees ready=0.
  - On a grant: latch addr/wen/wdata/wmask (IFU forces wen=0, wdata=0, wmask=0), set owner, clear tmo_cnt, go to REQ.
  - starve_cnt: incremented (saturating at STARVE_LIMIT) on an LSU grant while ifu_req_valid=1; cleared on an IFU grant; unchanged otherwise.
- REQ:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready go to WAIT.
  - A mem_resp_valid in the same cycle as mem_req_ready is honoured exactly as in WAIT.
- WAIT:
  - On mem_resp_valid: the owner's resp_valid=1 and resp_data=mem_resp_data (combinational pass-through), resp_err=0, next state IDLE.
  - The non-owner's response outputs stay 0.
- Timeout:
  - tmo_cnt increments every cycle in REQ or WAIT.
  - When TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with no mem_resp_valid in that cycle: owner resp_valid=1, resp_err=1, resp_data=0; mem_req_valid is deasserted; go to IDLE.
  - If mem_resp_valid arrives in the same cycle as the timeout, the normal response wins.
- mem_resp_valid while in IDLE, or in REQ before acceptance, is dropped silently.
- Throughput: request accepted at cycle T (IDLE); mem_req_valid from T+1. With mem_req_ready at T+1 and mem_resp_valid at T+2, the requester sees its response at T+2 and the next grant can occur at T+3. The minimum is one transaction per 3 cycles.
- The response pulse lasts exactly one cycle. Requesters must accept it unconditionally.
- Width rules: no address or data arithmetic. starve_cnt is 4 bits; tmo_cnt is 8 bits and does not wrap while TIMEOUT!=0.

Test Plan:
- IFU-only read, addr=0x80000000, mem_req_ready=1 immediately, response 0x00000413 one cycle later -> ifu_req_ready pulse at T, mem_req_valid at T+1 with mem_wen=0 and mem_wmask=0, ifu_resp_valid=1 and ifu_resp_data=0x00000413 at T+2, lsu outputs stay 0.
- IFU and LSU both valid continuously with LSU writes (addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF), STARVE_LIMIT=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU…, never two ready signals in one cycle.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_addr/mem_wdata/mem_wmask stable for all 5 cycles, then the transaction completes normally.
- TIMEOUT=8, no mem_resp_valid -> owner resp_valid=1, resp_err=1, resp_data=0 at the 8th cycle after entering REQ; back to IDLE; a stray mem_resp_valid one cycle later produces no pulse.
- mem_resp_valid coincident with the timeout cycle -> resp_err=0 and the data is passed through.
- rst asserted in WAIT -> next cycle all outputs 0 and state IDLE; the pending response is dropped; a fresh IFU request is granted normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch unit (IFU)
// and the load/store unit (LSU). Only one transaction is outstanding at a time.
// The LSU wins arbitration by default. After STARVE_LIMIT consecutive LSU grants
// with the IFU waiting, the IFU is forced to win.
// A per-transaction timeout turns a missing downstream response into an error
// response for the owner.

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int TIMEOUT      = 255  // 0 disables, 1..255 otherwise
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_data,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_data,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic       OWN_IFU    = 1'b0;
    localparam logic       OWN_LSU    = 1'b1;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    // Last counter value of a transaction. It is only used when TIMEOUT != 0,
    // so the TIMEOUT == 0 case never reaches this compare.
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic       TMO_EN     = (TIMEOUT != 0);

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_owner;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_tmo_cnt;
    logic        r_mem_req_valid;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_busy;
    logic w_ifu_starved;
    logic w_grant_lsu;
    logic w_grant_ifu;
    logic w_resp_hit;
    logic w_tmo_hit;
    logic w_done;

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = (r_state == ST_REQ) || (r_state == ST_WAIT);

    // The IFU is forced to win once the LSU has used up its run of grants.
    assign w_ifu_starved = ifu_req_valid && (r_starve_cnt == STARVE_MAX);
    assign w_grant_lsu   = w_idle && lsu_req_valid && !w_ifu_starved;
    assign w_grant_ifu   = w_idle && ifu_req_valid && !w_grant_lsu;

    // A response counts in WAIT, or in REQ when the request is accepted in
    // the same cycle. A response in REQ before acceptance is stray and ignored.
    assign w_resp_hit = mem_resp_valid &&
                        ((r_state == ST_WAIT) ||
                         ((r_state == ST_REQ) && mem_req_ready));

    // The timeout fires only when no real response is present. If both occur
    // in the same cycle, the real data wins.
    assign w_tmo_hit = TMO_EN && w_busy && (r_tmo_cnt == TMO_LAST) && !w_resp_hit;
    assign w_done    = w_resp_hit || w_tmo_hit;

    // The request-ready outputs go low while reset is held, so a requester
    // never sees a grant that the sequential logic will discard.
    assign ifu_req_ready = !rst && w_grant_ifu;
    assign lsu_req_ready = !rst && w_grant_lsu;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    // Route the completion (data or timeout error) to the owner only.
    always_comb begin
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = 32'd0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = 32'd0;
        lsu_resp_err   = 1'b0;
        if (!rst && w_done) begin
            if (r_owner == OWN_LSU) begin
                lsu_resp_valid = 1'b1;
                lsu_resp_err   = w_tmo_hit;
                lsu_resp_data  = w_resp_hit ? mem_resp_data : 32'd0;
            end else begin
                ifu_resp_valid = 1'b1;
                ifu_resp_err   = w_tmo_hit;
                ifu_resp_data  = w_resp_hit ? mem_resp_data : 32'd0;
            end
        end else begin
            ifu_resp_valid = 1'b0;
            lsu_resp_valid = 1'b0;
        end
    end

    // Transaction FSM: arbitration, request latch, starvation and timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_owner         <= OWN_IFU;
            r_starve_cnt    <= 4'd0;
            r_tmo_cnt       <= 8'd0;
            r_mem_req_valid <= 1'b0;
            r_addr          <= 32'd0;
            r_wen           <= 1'b0;
            r_wdata         <= 32'd0;
            r_wmask         <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_lsu) begin
                        r_owner         <= OWN_LSU;
                        r_addr          <= lsu_addr;
                        r_wen           <= lsu_wen;
                        r_wdata         <= lsu_wdata;
                        r_wmask         <= lsu_wmask;
                        r_tmo_cnt       <= 8'd0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_REQ;
                        // Count only the LSU grants that made a waiting IFU lose.
                        if (ifu_req_valid && (r_starve_cnt != STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end else begin
                            r_starve_cnt <= r_starve_cnt;
                        end
                    end else if (w_grant_ifu) begin
                        // Instruction fetch is always a read. Write fields are forced to zero.
                        r_owner         <= OWN_IFU;
                        r_addr          <= ifu_addr;
                        r_wen           <= 1'b0;
                        r_wdata         <= 32'd0;
                        r_wmask         <= 4'd0;
                        r_tmo_cnt       <= 8'd0;
                        r_mem_req_valid <= 1'b1;
                        r_starve_cnt    <= 4'd0;
                        r_state         <= ST_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_REQ: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    if (w_done) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_WAIT;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end

                ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end

                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Stimulus pushes the expected responses into per-requester queues. A monitor
// pops and compares them whenever a response pulse appears.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = 32'd0;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = 32'd0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [3:0]  lsu_wmask = 4'd0;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    // Memory side: either an automatic responder or manual drive.
    logic        auto_mem = 1'b0;
    logic [31:0] auto_data = 32'd0;
    logic        a_resp_valid = 1'b0;
    logic [31:0] a_resp_data = 32'd0;
    logic        acc_seen = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_resp_valid = 1'b0;
    logic [31:0] m_resp_data = 32'd0;

    assign mem_req_ready  = auto_mem ? 1'b1 : m_ready;
    assign mem_resp_valid = auto_mem ? a_resp_valid : m_resp_valid;
    assign mem_resp_data  = auto_mem ? a_resp_data : m_resp_data;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t ifu_q[$];
    resp_t lsu_q[$];
    resp_t e_ifu;
    resp_t e_lsu;
    string grants = "";
    logic  log_en = 1'b0;
    int    checks = 0;
    int    failures = 0;

    logic [12:0] all_outs;
    assign all_outs = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_resp_err,
                       lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen,
                       |mem_wmask, |ifu_resp_data, |lsu_resp_data, |mem_addr, |mem_wdata};

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Automatic responder: accepts immediately and answers the cycle after acceptance.
    always @(posedge clk) begin
        acc_seen = mem_req_valid && mem_req_ready;
        #2;
        a_resp_valid = auto_mem && acc_seen;
        a_resp_data  = (auto_mem && acc_seen) ? auto_data : 32'd0;
    end

    // Monitor: ready exclusivity, grant log, and scoreboard pops on response pulses.
    always @(negedge clk) begin
        if (ifu_req_ready || lsu_req_ready) begin
            chk1("one_ready", ifu_req_ready & lsu_req_ready, 1'b0);
            if (log_en) grants = {grants, (lsu_req_ready ? "L" : "I")};
        end
        if (ifu_resp_valid) begin
            if (ifu_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ifu_unexpected_resp actual=data %h err %b required=no pulse", ifu_resp_data, ifu_resp_err);
            end else begin
                e_ifu = ifu_q.pop_front();
                chk32("ifu_resp_data", ifu_resp_data, e_ifu.data);
                chk1("ifu_resp_err", ifu_resp_err, e_ifu.err);
                chk1("lsu_quiet_on_ifu_resp", lsu_resp_valid, 1'b0);
            end
        end
        if (lsu_resp_valid) begin
            if (lsu_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL lsu_unexpected_resp actual=data %h err %b required=no pulse", lsu_resp_data, lsu_resp_err);
            end else begin
                e_lsu = lsu_q.pop_front();
                chk32("lsu_resp_data", lsu_resp_data, e_lsu.data);
                chk1("lsu_resp_err", lsu_resp_err, e_lsu.err);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk32("reset_outputs_during_rst", {19'd0, all_outs}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk32("reset_outputs_after_rst", {19'd0, all_outs}, 32'd0);

        // ---------------- 1: IFU-only read ----------------
        cyc();
        auto_mem  = 1'b1;
        auto_data = 32'h0000_0413;
        ifu_q.push_back('{data: 32'h0000_0413, err: 1'b0});
        ifu_addr      = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        chk1("t1_ifu_ready_T", ifu_req_ready, 1'b1);
        chk1("t1_lsu_ready_T", lsu_req_ready, 1'b0);
        cyc();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk1("t1_mem_req_valid_T1", mem_req_valid, 1'b1);
        chk32("t1_mem_addr", mem_addr, 32'h8000_0000);
        chk1("t1_mem_wen", mem_wen, 1'b0);
        chk32("t1_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        cyc();
        @(negedge clk);
        chk1("t1_ifu_resp_T2", ifu_resp_valid, 1'b1);
        chk1("t1_lsu_resp_quiet", lsu_resp_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t1_ifu_resp_one_cycle", ifu_resp_valid, 1'b0);

        // ---------------- 2: starvation order ----------------
        cyc();
        auto_data = 32'h0000_00AA;
        for (int k = 0; k < 4; k++) lsu_q.push_back('{data: 32'h0000_00AA, err: 1'b0});
        ifu_q.push_back('{data: 32'h0000_00AA, err: 1'b0});
        lsu_q.push_back('{data: 32'h0000_00AA, err: 1'b0});
        grants        = "";
        log_en        = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (grants.len() >= 6) break;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        log_en        = 1'b0;
        repeat (4) cyc();
        checks++;
        if (grants != "LLLLIL") begin
            failures++;
            $display("FAIL grant_order actual=%s required=LLLLIL", grants);
        end
        chk32("t2_queues_drained", ifu_q.size() + lsu_q.size(), 32'd0);

        // ---------------- 3: mem_req_ready held low 5 cycles ----------------
        auto_mem      = 1'b0;
        m_ready       = 1'b0;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'h3;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        chk1("t3_lsu_ready", lsu_req_ready, 1'b1);
        cyc();
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'd0;
        lsu_wdata     = 32'd0;
        lsu_wmask     = 4'd0;
        lsu_wen       = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("t3_hold_valid", mem_req_valid, 1'b1);
            chk32("t3_hold_addr", mem_addr, 32'h8000_2000);
            chk32("t3_hold_wdata", mem_wdata, 32'h1234_5678);
            chk32("t3_hold_wmask", {28'd0, mem_wmask}, 32'h0000_0003);
            chk1("t3_hold_wen", mem_wen, 1'b1);
            cyc();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk1("t3_valid_at_accept", mem_req_valid, 1'b1);
        cyc();
        m_ready      = 1'b0;
        lsu_q.push_back('{data: 32'h55AA_00FF, err: 1'b0});
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h55AA_00FF;
        @(negedge clk);
        chk1("t3_lsu_resp", lsu_resp_valid, 1'b1);
        cyc();
        m_resp_valid = 1'b0;
        m_resp_data  = 32'd0;
        @(negedge clk);
        chk1("t3_resp_done", lsu_resp_valid, 1'b0);
        chk1("t3_req_dropped", mem_req_valid, 1'b0);

        // ---------------- 4: timeout then stray response ----------------
        cyc();
        ifu_q.push_back('{data: 32'h0000_0000, err: 1'b1});
        ifu_addr      = 32'h8000_0040;
        ifu_req_valid = 1'b1;
        cyc();
        ifu_req_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            chk1("t4_no_early_resp", ifu_resp_valid, 1'b0);
            cyc();
        end
        @(negedge clk);
        chk1("t4_tmo_resp_cycle8", ifu_resp_valid, 1'b1);
        cyc();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hDEAD_DEAD;
        @(negedge clk);
        chk1("t4_stray_ifu", ifu_resp_valid, 1'b0);
        chk1("t4_stray_lsu", lsu_resp_valid, 1'b0);
        chk1("t4_req_valid_idle", mem_req_valid, 1'b0);
        cyc();
        m_resp_valid = 1'b0;
        m_resp_data  = 32'd0;

        // ---------------- 5: response coincident with timeout ----------------
        lsu_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
        lsu_addr      = 32'h8000_3000;
        lsu_wen       = 1'b0;
        lsu_req_valid = 1'b1;
        cyc();
        lsu_req_valid = 1'b0;
        m_ready       = 1'b1;
        cyc();
        m_ready = 1'b0;
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            chk1("t5_no_early_resp", lsu_resp_valid, 1'b0);
            cyc();
        end
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("t5_resp_at_tmo", lsu_resp_valid, 1'b1);
        cyc();
        m_resp_valid = 1'b0;
        m_resp_data  = 32'd0;
        @(negedge clk);
        chk1("t5_single_pulse", lsu_resp_valid, 1'b0);

        // ---------------- 6: reset in WAIT ----------------
        cyc();
        ifu_addr      = 32'h8000_0080;
        ifu_req_valid = 1'b1;
        cyc();
        ifu_req_valid = 1'b0;
        m_ready       = 1'b1;
        cyc();
        m_ready = 1'b0;
        rst     = 1'b1;
        cyc();
        rst          = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h1111_1111;
        @(negedge clk);
        chk32("t6_outputs_after_rst", {19'd0, all_outs}, 32'd0);
        cyc();
        m_resp_valid = 1'b0;
        m_resp_data  = 32'd0;
        auto_mem     = 1'b1;
        auto_data    = 32'h0010_0073;
        ifu_q.push_back('{data: 32'h0010_0073, err: 1'b0});
        ifu_addr      = 32'h8000_0100;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        chk1("t6_fresh_grant", ifu_req_ready, 1'b1);
        cyc();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk32("t6_fresh_addr", mem_addr, 32'h8000_0100);
        repeat (4) cyc();

        chk32("final_ifu_q_empty", ifu_q.size(), 32'd0);
        chk32("final_lsu_q_empty", lsu_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
